scoreboard: RTL
===============

SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default NR_SB_ENTRIES (4), the entry count; it SHALL be a power of two.
REQ-002 SHALL have parameter NR_WB_PORTS, default NR_WB_PORTS (4), the number of writeback ports.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 flush_i  in  1  discard all entries.
REQ-006 decoded_instr_i  in  scoreboard_entry  instruction pushed by decode.
REQ-007 decoded_instr_valid_i  in  1  push request.
REQ-008 decoded_instr_ack_o  out  1  push accepted this cycle.
REQ-009 issue_trans_id_o  out  TRANS_ID_BITS  index assigned to an accepted push.
REQ-010 full_o  out  1  all entries occupied.
REQ-011 trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  writeback target entry.
REQ-012 wdata_i  in  NR_WB_PORTS x 64  writeback result.
REQ-013 wb_valid_i  in  NR_WB_PORTS  writeback strobe.
REQ-014 ex_i  in  NR_WB_PORTS x exception  writeback exception.
REQ-015 commit_instr_o  out  scoreboard_entry  oldest entry.
REQ-016 commit_valid_o  out  1  oldest entry is ready to commit.
REQ-017 commit_ack_i  in  1  commit consumes the oldest entry.
REQ-018 rs1_i, rs2_i  in  5 each  source registers to look up.
REQ-019 rs1_o, rs2_o  out  64 each  forwarded operand values.
REQ-020 rs1_valid_o, rs2_valid_o  out  1 each  forwarded value is usable.
REQ-021 rs1_busy_o, rs2_busy_o  out  1 each  producer is in flight without a result.

Function
REQ-022 SHALL store entries in a circular buffer with head (commit) pointer, tail (push) pointer, and a count of TRANS_ID_BITS+1 bits.
REQ-023 decoded_instr_ack_o SHALL equal decoded_instr_valid_i AND NOT full_o AND NOT flush_i, with no combinational path from commit_ack_i.
REQ-024 On push, SHALL write the entry at the tail with trans_id = tail and valid = 0; result (the immediate) SHALL be kept.
REQ-025 On push, SHALL increment the tail modulo NR_ENTRIES; issue_trans_id_o SHALL equal the tail.
REQ-026 full_o SHALL be 1 when count == NR_ENTRIES; a push at full SHALL NOT be accepted even if a commit occurs in the same cycle.
REQ-027 For each port with wb_valid_i set that targets an occupied entry, SHALL set result = wdata_i and valid = 1.
REQ-028 On such a writeback, ex SHALL be set to ex_i only when ex_i.valid is 1.
REQ-029 A writeback to an unoccupied entry SHALL be ignored.
REQ-030 When several ports target the same entry in one cycle, the lowest-numbered port SHALL win.
REQ-031 commit_instr_o SHALL be the head entry.
REQ-032 commit_valid_o SHALL be 1 when count != 0 AND (head.valid OR head.ex.valid).
REQ-033 commit_ack_i while commit_valid_o is 1 SHALL advance the head and decrement the count; commit_ack_i while commit_valid_o is 0 SHALL be ignored.
REQ-034 A simultaneous push and commit SHALL leave the count unchanged.
REQ-035 Commit SHALL be in order only; a younger ready entry SHALL NOT commit before the head.
REQ-036 Operand lookup SHALL be combinational over the occupied entries, using the youngest entry whose rd equals rs.
REQ-037 If that youngest entry has valid = 1, then rs_o = its result, rs_valid_o = 1 and rs_busy_o = 0.
REQ-038 If that youngest entry has valid = 0, then rs_valid_o = 0 and rs_busy_o = 1.
REQ-039 If no entry matches, or rs == 0, then rs_valid_o = 0 and rs_busy_o = 0.
REQ-040 Lookup SHALL reflect register state only and SHALL NOT forward same-cycle writeback data.
REQ-041 flush_i SHALL clear the count, head, tail and every valid bit on the next edge.
REQ-042 flush_i SHALL override push, writeback and commit in the same cycle.

Reset
REQ-043 On rst_ni low, SHALL asynchronously clear the pointers, count and all entry fields to 0.
REQ-044 While in reset, full_o, decoded_instr_ack_o, commit_valid_o and all rs_valid_o/rs_busy_o SHALL be 0.
REQ-045 Reset asserted mid-operation SHALL discard all in-flight entries; operation SHALL resume from an empty buffer after release.

Verification
REQ-046 Four pushes, no writeback -> issue_trans_id_o = 0,1,2,3, full_o=1; fifth push gets ack=0, commit_valid_o=0.
REQ-047 Entries 0..2 pushed, writeback ids 2 then 1 -> commit_valid_o stays 0; writeback id 0 -> commits 0,1,2 on consecutive acked cycles.
REQ-048 Entry 0 rd=5 written 0xA, entry 1 rd=5 pending, rs1_i=5 -> busy=1, valid=0; wb id1 0xB -> rs1_o=0xB, valid=1; rs1_i=0 -> busy=0, valid=0.
REQ-049 Six pushes interleaved with commits -> trans_ids 0,1,2,3,0,1; at full, a push and commit in the same cycle -> push not acked, count drops to 3.
REQ-050 Three occupied entries, flush_i with push and writeback in the same cycle -> next cycle count=0, full_o=0, commit_valid_o=0, push ack=0.
REQ-051 rst_ni pulsed low with 2 entries pending -> all outputs 0 immediately; the next push receives trans_id 0.

Source files
------------

// File: rtl/scoreboard.sv
// Scoreboard: a circular buffer of in-flight instructions. Decode pushes
// entries at the tail. Functional units write results back by transaction
// id. Entries commit strictly in order from the head. Source operands are
// forwarded from the youngest in-flight producer of each register.

package scoreboard_pkg;
    localparam int NR_SB_ENTRIES = 4;
    localparam int NR_WB_PORTS   = 4;
    localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;
endpackage

module scoreboard #(
    parameter int  NR_ENTRIES    = scoreboard_pkg::NR_SB_ENTRIES,
    parameter int  NR_WB_PORTS   = scoreboard_pkg::NR_WB_PORTS,
    localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  scoreboard_pkg::scoreboard_entry_t         decoded_instr_i,
    input  logic                                      decoded_instr_valid_i,
    output logic                                      decoded_instr_ack_o,
    output logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o,
    output logic                                      full_o,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]              wdata_i,
    input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
    input  scoreboard_pkg::exception_t [NR_WB_PORTS-1:0] ex_i,
    output scoreboard_pkg::scoreboard_entry_t         commit_instr_o,
    output logic                                      commit_valid_o,
    input  logic                                      commit_ack_i,
    input  logic [4:0]                                rs1_i,
    input  logic [4:0]                                rs2_i,
    output logic [63:0]                               rs1_o,
    output logic [63:0]                               rs2_o,
    output logic                                      rs1_valid_o,
    output logic                                      rs2_valid_o,
    output logic                                      rs1_busy_o,
    output logic                                      rs2_busy_o
);
    localparam int SB_ID_W = scoreboard_pkg::TRANS_ID_BITS;
    localparam int PORT_W  = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;
    localparam logic [TRANS_ID_BITS:0] FULL_COUNT = (TRANS_ID_BITS+1)'(NR_ENTRIES);

    scoreboard_pkg::scoreboard_entry_t r_mem [NR_ENTRIES];
    logic [TRANS_ID_BITS-1:0] r_head;
    logic [TRANS_ID_BITS-1:0] r_tail;
    logic [TRANS_ID_BITS:0]   r_count;

    scoreboard_pkg::scoreboard_entry_t w_push_entry;
    logic                                w_push;
    logic                                w_commit;
    logic [TRANS_ID_BITS-1:0]            w_age [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]               w_occupied;
    logic [NR_ENTRIES-1:0]               w_wb_hit;
    logic [NR_ENTRIES-1:0][PORT_W-1:0]   w_wb_port;
    logic [1:0][4:0]                     w_rs;
    logic [1:0]                          w_hit;
    logic [1:0]                          w_rdy;
    logic [1:0][63:0]                    w_fwd;

    // Reset is folded into the ack so nothing is accepted while held in reset.
    assign full_o              = (r_count == FULL_COUNT);
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i & rst_ni;
    assign issue_trans_id_o    = r_tail;
    assign w_push              = decoded_instr_ack_o;

    assign commit_instr_o = r_mem[r_head];
    assign commit_valid_o = (r_count != '0) && (r_mem[r_head].valid || r_mem[r_head].ex.valid);
    assign w_commit       = commit_ack_i & commit_valid_o & ~flush_i;

    // An entry is occupied when its distance from the head is below the count.
    for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_occ
        assign w_age[g]      = TRANS_ID_BITS'(g) - r_head;
        assign w_occupied[g] = ({1'b0, w_age[g]} < r_count);
    end

    // The pushed entry is tagged with its slot index and starts without a result.
    always_comb begin
        w_push_entry          = decoded_instr_i;
        w_push_entry.trans_id = SB_ID_W'(r_tail);
        w_push_entry.valid    = 1'b0;
    end

    // Pick one writeback port per entry; scanning downward lets the lowest port win.
    always_comb begin
        w_wb_hit  = '0;
        w_wb_port = '0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (trans_id_i[p] == TRANS_ID_BITS'(e)) && w_occupied[e]) begin
                    w_wb_hit[e]  = 1'b1;
                    w_wb_port[e] = PORT_W'(p);
                end
            end
        end
    end

    // Walk the occupied entries from oldest to youngest so the last match is the youngest producer.
    assign w_rs = {rs2_i, rs1_i};
    always_comb begin
        w_hit = '0;
        w_rdy = '0;
        w_fwd = '0;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            for (int s = 0; s < 2; s++) begin
                if (((TRANS_ID_BITS+1)'(k) < r_count) && (w_rs[s] != 5'd0) &&
                    (r_mem[r_head + TRANS_ID_BITS'(k)].rd == w_rs[s])) begin
                    w_hit[s] = 1'b1;
                    w_rdy[s] = r_mem[r_head + TRANS_ID_BITS'(k)].valid;
                    w_fwd[s] = r_mem[r_head + TRANS_ID_BITS'(k)].result;
                end
            end
        end
    end

    assign rs1_valid_o = w_hit[0] & w_rdy[0];
    assign rs2_valid_o = w_hit[1] & w_rdy[1];
    assign rs1_busy_o  = w_hit[0] & ~w_rdy[0];
    assign rs2_busy_o  = w_hit[1] & ~w_rdy[1];
    assign rs1_o       = rs1_valid_o ? w_fwd[0] : 64'd0;
    assign rs2_o       = rs2_valid_o ? w_fwd[1] : 64'd0;

    // Head, tail and count move with push/commit; flush empties the buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + TRANS_ID_BITS'(1);
            end
            if (w_commit) begin
                r_head <= r_head + TRANS_ID_BITS'(1);
            end
            if (w_push && !w_commit) begin
                r_count <= r_count + (TRANS_ID_BITS+1)'(1);
            end else if (!w_push && w_commit) begin
                r_count <= r_count - (TRANS_ID_BITS+1)'(1);
            end
        end
    end

    // Entry storage: push fills the tail slot, writebacks fill results of occupied slots.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                r_mem[e] <= '0;
            end
        end else if (flush_i) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                r_mem[e].valid    <= 1'b0;
                r_mem[e].ex.valid <= 1'b0;
            end
        end else begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (w_push && (r_tail == TRANS_ID_BITS'(e))) begin
                    r_mem[e] <= w_push_entry;
                end else if (w_wb_hit[e]) begin
                    r_mem[e].result <= wdata_i[w_wb_port[e]];
                    r_mem[e].valid  <= 1'b1;
                    if (ex_i[w_wb_port[e]].valid) begin
                        r_mem[e].ex <= ex_i[w_wb_port[e]];
                    end
                end
            end
        end
    end
endmodule
